// File: rtl/multiport_mem_ctrl.sv
// multiport_mem_ctrl: round-robin arbiter for NUM_PORTS burst requesters
// onto the byte-serial RAM/IO bus. Each grant becomes a 1..MAX_BYTES read
// or write burst at consecutive addresses.
// Optional feature macro: MULTIPORT_MEM_CTRL_BACK_TO_BACK_EN -- when defined,
// arbitration also runs in DONE so the next burst starts one cycle earlier.
module multiport_mem_ctrl #(
  parameter int                   NUM_PORTS   = 2,
  parameter int                   BURST_WIDTH = 4,
  parameter logic [NUM_PORTS-1:0] FLUSH_MASK  = 2'b10
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic                                    rdy_in,
  input  logic                                    io_buffer_full,
  input  logic [7:0]                              mem_din,
  output logic [7:0]                              mem_dout,
  output logic [31:0]                             mem_a,
  output logic                                    mem_wr,
  input  logic [NUM_PORTS-1:0]                    req_valid,
  input  logic [NUM_PORTS-1:0]                    req_write,
  input  logic [32*NUM_PORTS-1:0]                 req_addr,
  input  logic [BURST_WIDTH*NUM_PORTS-1:0]        req_len,
  input  logic [(8<<BURST_WIDTH)*NUM_PORTS-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]                    req_ready,
  output logic [NUM_PORTS-1:0]                    resp_valid,
  output logic [(8<<BURST_WIDTH)-1:0]             resp_rdata,
  input  logic                                    flush_in
);
  localparam int MAX_BYTES = 1 << BURST_WIDTH;
  localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
`ifdef MULTIPORT_MEM_CTRL_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RUN_RD, RUN_WR, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [31:0]                addr;
    logic [BURST_WIDTH-1:0]     len;
    logic                       write;
    logic [MAX_BYTES-1:0][7:0]  wdata;
    logic [PW-1:0]              port;
  } req_t;

  state_t                    state, state_d;
  req_t                      cur, greq;
  logic [PW-1:0]             rr_ptr, grant_id;
  logic [BURST_WIDTH-1:0]    k, cap_idx;
  logic                      rd_pend;
  logic [MAX_BYTES-1:0][7:0] rdata_q;
  logic [NUM_PORTS-1:0]      eligible;
  logic                      grant_any, grant, arb_en, run, io_stall, last_byte, flush_kill;

  // A flush hides masked ports from arbitration for that cycle.
  assign eligible  = req_valid & ~({NUM_PORTS{flush_in}} & FLUSH_MASK);
  assign arb_en    = rdy_in && !rst_in && (state == IDLE || (B2B && state == DONE));
  assign grant     = arb_en && grant_any;

  assign run       = (state == RUN_RD) || (state == RUN_WR);
  assign mem_a     = run ? cur.addr + 32'(k) : 32'h0;
  assign io_stall  = (mem_a[17:16] == 2'b11) && io_buffer_full;
  assign mem_wr    = (state == RUN_WR) && rdy_in && !io_stall;
  assign mem_dout  = (state == RUN_WR) ? cur.wdata[k] : 8'h0;
  assign last_byte = (k == cur.len);
  assign flush_kill = flush_in && FLUSH_MASK[cur.port];
  assign resp_rdata = rdata_q;

  // Round-robin search upward from rr_ptr; also gathers the winner's fields.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    greq      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_id  = PW'(idx);
      end
    end
    greq.addr  = req_addr[32*int'(grant_id) +: 32];
    greq.len   = req_len[BURST_WIDTH*int'(grant_id) +: BURST_WIDTH];
    greq.write = req_write[grant_id];
    greq.wdata = req_wdata[8*MAX_BYTES*int'(grant_id) +: 8*MAX_BYTES];
    greq.port  = grant_id;
  end

  // Per-port grant and completion pulses; both are held off while paused.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_ready[p]  = grant && (grant_id == PW'(p));
      resp_valid[p] = (state == DONE) && rdy_in && (cur.port == PW'(p));
    end
  end

  // Next-state logic; everything holds while rdy_in is low.
  always_comb begin
    state_d = state;
    if (rdy_in) begin
      case (state)
        IDLE:    if (grant) state_d = greq.write ? RUN_WR : RUN_RD;
        RUN_RD:  if (flush_kill) state_d = IDLE;
                 else if (last_byte) state_d = DRAIN;
        RUN_WR:  if (!io_stall && last_byte) state_d = DONE;
        DRAIN:   state_d = flush_kill ? IDLE : DONE;
        DONE:    if (grant) state_d = greq.write ? RUN_WR : RUN_RD;
                 else state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_d;
  end

  // Latch the granted request, rotate the pointer and step the byte counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr <= '0;
      cur    <= '0;
      k      <= '0;
    end else if (rdy_in) begin
      if (grant) begin
        cur    <= greq;
        k      <= '0;
        rr_ptr <= (grant_id == PW'(NUM_PORTS-1)) ? '0 : grant_id + 1'b1;
      end else if (state == RUN_RD && !last_byte) begin
        k <= k + 1'b1;
      end else if (mem_wr && !last_byte) begin
        k <= k + 1'b1;
      end
    end
  end

  // Read capture one cycle after an issued address, even if that cycle is
  // paused, so a byte in flight is never dropped. A new grant clears the buffer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_pend <= 1'b0;
      cap_idx <= '0;
      rdata_q <= '0;
    end else begin
      rd_pend <= rdy_in && (state == RUN_RD);
      cap_idx <= k;
      if (rd_pend) rdata_q[cap_idx] <= mem_din;
      if (grant)   rdata_q <= '0;
    end
  end
endmodule
